pool_window_buf: RTL
====================

POOL_WINDOW_BUF -- requirements
Module: pool_window_buf

Interface
REQ-001 Parameter bits, default 16, width of one pixel word.
REQ-002 Parameter bits_shift, default 4, log2 of the pixel slot width in the packed window (slot = 1<<bits_shift, at least bits).
REQ-003 Parameter pool_size, default 4, pixels per window (fixed 2x2).
REQ-004 Parameter img_width, default 8, pixels per row; SHALL be even and at least 2.
REQ-005 Parameter img_height, default 8, rows per frame; SHALL be even and at least 2.
REQ-006 Parameter cnt_bits, default 3, width of the column and row counters; 2^cnt_bits SHALL be at least max(img_width, img_height).
REQ-007 clk_in  input  1  single clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 pixel_in  input  bits  streamed pixel, raster order, row-major.
REQ-010 pixel_valid  input  1  pixel_in accepted on a rising edge while high; gaps allowed.
REQ-011 sof  input  1  start of frame; qualified by pixel_valid; that pixel is (row 0, col 0).
REQ-012 data_out  output  pool_size<<bits_shift  packed 2x2 window for the downstream max-pool stage.
REQ-013 start  output  1  one-cycle pulse; data_out valid in the same cycle.
REQ-014 frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-015 win_cnt  output  16  windows emitted in the current frame.

Function
REQ-016 Slot packing SHALL be: slot 0 = top-left, slot 1 = top-right, slot 2 = bottom-left, slot 3 = bottom-right, with slot k at bits [(k<<bits_shift)+bits-1 : k<<bits_shift]; unused upper slot bits are 0.
REQ-017 The FSM SHALL have states FILL (even row: write pixels into a line buffer of img_width words at index col) and POOL (odd row: read the line buffer).
REQ-018 In POOL, an accepted pixel at an even col SHALL be held in a bottom-left register.
REQ-019 In POOL, an accepted pixel at an odd col SHALL cause data_out = {pixel_in, held_bl, linebuf[col], linebuf[col-1]} and start=1 on the next cycle (1-cycle latency, registered).
REQ-020 data_out SHALL hold its value until the next window is produced.
REQ-021 start SHALL pulse at most once per two accepted pixels; the downstream 2-cycle window is therefore always met.
REQ-022 col SHALL increment per accepted pixel and wrap to 0 at img_width-1.
REQ-023 On each col wrap, row SHALL increment and the FSM SHALL toggle FILL<->POOL.
REQ-024 At row img_height-1 with col wrap, row SHALL wrap to 0, the FSM SHALL enter FILL, and frame_done SHALL pulse in the next cycle, coincident with the final start.
REQ-025 win_cnt SHALL increment together with each start pulse.
REQ-026 win_cnt SHALL clear on the cycle after frame_done.
REQ-027 sof with pixel_valid SHALL force col=0, row=0, and FILL mode, write that pixel at index 0, and clear win_cnt, abandoning any partial frame without a frame_done.
REQ-028 pixel_valid low SHALL freeze all counters, the FSM and the buffers; start and frame_done SHALL be 0.
REQ-029 A frame completed with img_width*img_height pixels SHALL yield exactly (img_width/2)*(img_height/2) start pulses.

Reset
REQ-030 While rst_n is low, the following SHALL be 0: data_out, start, frame_done, win_cnt, col, row, and the held register; the FSM SHALL be in FILL.
REQ-031 Line buffer contents need not be reset; every entry is overwritten in FILL before it is read.
REQ-032 Reset asserted mid-frame SHALL abort the frame; the first pixel after release is (0,0).

Verification (img_width=4, img_height=4)
REQ-033 Pixels 0..15 back-to-back with sof on pixel 0 -> starts with data_out = {5,4,1,0}, {7,6,3,2}, {13,12,9,8}, {15,14,11,10}; frame_done with the 4th start; win_cnt 1..4.
REQ-034 Same stream with pixel_valid low every other cycle -> identical windows, start never on an idle cycle's successor.
REQ-035 sof reasserted after pixel 6, then pixels 100..115 -> no frame_done for the aborted frame; first window {105,104,101,100}.
REQ-036 rst_n pulsed low after pixel 9 -> all outputs 0 immediately; a fresh stream 0..15 reproduces REQ-033.
REQ-037 Two frames back-to-back without a second sof -> 8 start pulses, 2 frame_done pulses, win_cnt restarts at 1.

Source files
------------

// File: rtl/pool_window_buf.sv
// 2x2 pooling window former: buffers even rows in a line buffer and emits a
// packed 2x2 window on every odd-row, odd-column pixel of a raster stream.
module pool_window_buf #(
    parameter int bits       = 16,
    parameter int bits_shift = 4,
    parameter int pool_size  = 4,
    parameter int img_width  = 8,
    parameter int img_height = 8,
    parameter int cnt_bits   = 3
) (
    input  logic                              clk_in,
    input  logic                              rst_n,
    input  logic [bits-1:0]                   pixel_in,
    input  logic                              pixel_valid,
    input  logic                              sof,
    output logic [(pool_size<<bits_shift)-1:0] data_out,
    output logic                              start,
    output logic                              frame_done,
    output logic [15:0]                       win_cnt
);

    localparam int slot_w = 1 << bits_shift;
    localparam int dout_w = pool_size << bits_shift;
    localparam int idx_w  = (img_width > 1) ? $clog2(img_width) : 1;

    localparam logic [cnt_bits-1:0] last_col = cnt_bits'(img_width - 1);
    localparam logic [cnt_bits-1:0] last_row = cnt_bits'(img_height - 1);
    localparam logic [cnt_bits-1:0] cnt_one  = cnt_bits'(1);
    localparam logic [idx_w-1:0]    idx_one  = idx_w'(1);

    typedef enum logic {
        FILL = 1'b0,
        POOL = 1'b1
    } state_t;

    state_t state_q, state_d, cur_state;

    logic [cnt_bits-1:0] col_q, col_d, cur_col;
    logic [cnt_bits-1:0] row_q, row_d, cur_row;
    logic [bits-1:0]     linebuf [img_width];
    logic [bits-1:0]     held_bl_q;

    logic              sof_acc;
    logic              win_fire;
    logic              hold_fire;
    logic              fill_wr;
    logic              frame_end;
    logic [idx_w-1:0]  wr_idx;
    logic [idx_w-1:0]  tl_idx;
    logic [dout_w-1:0] win_word;

    // A qualified sof re-anchors the accepted pixel at (0,0) in FILL.
    always_comb begin
        sof_acc   = pixel_valid & sof;
        cur_col   = sof_acc ? '0 : col_q;
        cur_row   = sof_acc ? '0 : row_q;
        cur_state = sof_acc ? FILL : state_q;
    end

    always_comb begin
        fill_wr   = pixel_valid & (cur_state == FILL);
        hold_fire = pixel_valid & (cur_state == POOL) & ~cur_col[0];
        win_fire  = pixel_valid & (cur_state == POOL) &  cur_col[0];
        wr_idx    = cur_col[idx_w-1:0];
        tl_idx    = wr_idx - idx_one;
    end

    // Next-state logic: position and mode advance only on accepted pixels.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        frame_end = 1'b0;
        if (pixel_valid) begin
            state_d = cur_state;
            col_d   = cur_col + cnt_one;
            row_d   = cur_row;
            if (cur_col == last_col) begin
                col_d = '0;
                if (cur_row == last_row) begin
                    row_d     = '0;
                    state_d   = FILL;
                    frame_end = 1'b1;
                end else begin
                    row_d   = cur_row + cnt_one;
                    state_d = (cur_state == FILL) ? POOL : FILL;
                end
            end
        end
    end

    // Slot 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right; pad bits stay 0.
    always_comb begin
        win_word = '0;
        win_word[0*slot_w +: bits] = linebuf[tl_idx];
        win_word[1*slot_w +: bits] = linebuf[wr_idx];
        win_word[2*slot_w +: bits] = held_bl_q;
        win_word[3*slot_w +: bits] = pixel_in;
    end

    // Line buffer is never read before it is written in the same frame.
    always_ff @(posedge clk_in) begin
        if (fill_wr) begin
            linebuf[wr_idx] <= pixel_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            held_bl_q  <= '0;
            data_out   <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start      <= win_fire;
            frame_done <= frame_end;
            if (hold_fire) begin
                held_bl_q <= pixel_in;
            end
            if (win_fire) begin
                data_out <= win_word;
            end
        end
    end

    // Count clears on sof or one cycle after frame_done; no window can coincide.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (sof_acc || frame_done) begin
            win_cnt <= '0;
        end else if (win_fire) begin
            win_cnt <= win_cnt + 16'd1;
        end
    end

endmodule
